r_channel_mux: RTL and testbench
================================

R_CHANNEL_MUX -- requirements
Module: r_channel_mux

Interface
REQ-001 SHALL have parameter NS, default 7, meaning slave ports S0..S5 plus SDEFAULT (index 6); widths come from AXI_define.svh (AXI_ID_BITS=4, AXI_IDS_BITS=8, AXI_DATA_BITS=32).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 RID_Sk  input  AXI_IDS_BITS  per slave k (S0..S5, SDEFAULT); [7:4] is the master tag, [3:0] is the master ID.
REQ-005 RDATA_Sk  input  AXI_DATA_BITS  per slave.
REQ-006 RRESP_Sk  input  2  per slave.
REQ-007 RLAST_Sk  input  1  per slave.
REQ-008 RVALID_Sk  input  1  per slave.
REQ-009 RREADY_Sk  output  1  per slave.
REQ-010 RID_Mm  output  AXI_ID_BITS  per master m (M0, M1).
REQ-011 RDATA_Mm  output  AXI_DATA_BITS  per master.
REQ-012 RRESP_Mm  output  2  per master.
REQ-013 RLAST_Mm  output  1  per master.
REQ-014 RVALID_Mm  output  1  per master.
REQ-015 RREADY_Mm  input  1  per master.

Function
REQ-016 Routing tag: RID_Sk[7:4]=4'b0001 selects M0, 4'b0010 selects M1; any other tag is "orphan".
REQ-017 Each master has an independent lane: a 2-state FSM (IDLE, LOCK), a 3-bit grant register and a 3-bit round-robin pointer; the two lanes run concurrently and never share a slave.
REQ-018 IDLE candidates for lane m: slaves with RVALID_Sk=1 and tag selecting m; pick the first candidate searching k = ptr, ptr+1, ... wrapping from 6 to 0.
REQ-019 Forwarding is combinational, with zero added latency: RVALID_Mm, RDATA_Mm, RRESP_Mm, RLAST_Mm and RID_Mm=RID_Sg[3:0] come from the selected slave g; RREADY_Sg=RREADY_Mm.
REQ-020 Selected slave: in IDLE it is the REQ-018 pick; in LOCK it is the grant register.
REQ-021 IDLE to LOCK: on a handshake (RVALID_Mm & RREADY_Mm) with RLAST=0; grant register <= g.
REQ-022 LOCK to IDLE: on a handshake with RLAST=1; ptr <= g+1 mod 7.
REQ-023 IDLE single-beat (RLAST=1 handshake): stay IDLE; ptr <= g+1 mod 7.
REQ-024 In LOCK, the lane ignores every other slave; if the locked slave drops RVALID, RVALID_Mm=0 and the lane stays locked.
REQ-025 With no candidates: RVALID_Mm=0, data outputs 0, FSM and ptr hold.
REQ-026 RREADY_Sk=0 for every valid, tag-matched slave that is not selected, so no beat is lost.
REQ-027 An orphan slave gets RREADY_Sk=1 (drained) and its beats are not forwarded.
REQ-028 A slave with RVALID_Sk=0 gets RREADY_Sk=0.
REQ-029 RREADY_Mm=0 with a valid beat: hold the selection; no ptr or FSM change.

Reset
REQ-030 While rst=0: both lanes are IDLE, grant and ptr are 0, and all RVALID_Mm, RREADY_Sk and master data outputs are forced to 0.
REQ-031 Reset asserted mid-burst aborts the lock immediately; after release, arbitration restarts from ptr=0.

Verification
REQ-032 Single beat: S1 RVALID, RID=8'h13, RDATA=32'hDEAD_BEEF, RLAST=1, RREADY_M0=1 -> same cycle RVALID_M0=1, RID_M0=4'h3, RREADY_S1=1; next cycle lane0 is IDLE with ptr=2.
REQ-033 Burst lock: S2 sends a 4-beat burst to M0 (tag 1) while S0 raises RVALID to M0 at beat 2 -> RREADY_S0=0 until the S2 RLAST handshake; S0 is granted next cycle (ptr=3 wraps to 0).
REQ-034 Concurrency: S5 bursts to M0 and S3 bursts to M1 simultaneously -> both forwarded every cycle, no stalls, no cross-routing.
REQ-035 Round-robin fairness: S0 and S4 both continuously send single beats to M1 -> grants alternate S0, S4, S0, S4.
REQ-036 Orphan plus backpressure: SDEFAULT has RID tag 4'b0100 -> RREADY_SDEFAULT=1 and no master RVALID; separately, RREADY_M0=0 for 3 cycles mid-burst -> data held stable and the slave stalled.
REQ-037 Reset mid-burst: rst=0 during beat 2 of an S1 to M0 burst -> all outputs 0 immediately; after release lane0 is IDLE and ptr=0.

Source files
------------

// File: rtl/r_channel_mux.sv
// r_channel_mux: routes AXI read data from seven slaves to two masters by RID tag, with a round-robin, burst-locking lane per master
module r_channel_mux #(
  parameter int NS        = 7,
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDS_BITS-1:0]  RID_S0, RID_S1, RID_S2, RID_S3, RID_S4, RID_S5, RID_SDEFAULT,
  input  logic [DATA_BITS-1:0] RDATA_S0, RDATA_S1, RDATA_S2, RDATA_S3, RDATA_S4, RDATA_S5, RDATA_SDEFAULT,
  input  logic [1:0]           RRESP_S0, RRESP_S1, RRESP_S2, RRESP_S3, RRESP_S4, RRESP_S5, RRESP_SDEFAULT,
  input  logic                 RLAST_S0, RLAST_S1, RLAST_S2, RLAST_S3, RLAST_S4, RLAST_S5, RLAST_SDEFAULT,
  input  logic                 RVALID_S0, RVALID_S1, RVALID_S2, RVALID_S3, RVALID_S4, RVALID_S5, RVALID_SDEFAULT,
  output logic                 RREADY_S0, RREADY_S1, RREADY_S2, RREADY_S3, RREADY_S4, RREADY_S5, RREADY_SDEFAULT,
  output logic [ID_BITS-1:0]   RID_M0, RID_M1,
  output logic [DATA_BITS-1:0] RDATA_M0, RDATA_M1,
  output logic [1:0]           RRESP_M0, RRESP_M1,
  output logic                 RLAST_M0, RLAST_M1,
  output logic                 RVALID_M0, RVALID_M1,
  input  logic                 RREADY_M0, RREADY_M1
);
  typedef enum logic {IDLE, LOCK} state_t;
  logic [IDS_BITS-1:0]  rid   [NS];
  logic [DATA_BITS-1:0] rdata [NS];
  logic [1:0]           rresp [NS];
  logic [NS-1:0]        rlast, vld, rready;
  logic [1:0]           mrdy, mv;
  logic [5:0]           sel_v;
  assign rid   = '{RID_S0, RID_S1, RID_S2, RID_S3, RID_S4, RID_S5, RID_SDEFAULT};
  assign rdata = '{RDATA_S0, RDATA_S1, RDATA_S2, RDATA_S3, RDATA_S4, RDATA_S5, RDATA_SDEFAULT};
  assign rresp = '{RRESP_S0, RRESP_S1, RRESP_S2, RRESP_S3, RRESP_S4, RRESP_S5, RRESP_SDEFAULT};
  assign rlast = {RLAST_SDEFAULT, RLAST_S5, RLAST_S4, RLAST_S3, RLAST_S2, RLAST_S1, RLAST_S0};
  assign vld   = {RVALID_SDEFAULT, RVALID_S5, RVALID_S4, RVALID_S3, RVALID_S2, RVALID_S1, RVALID_S0};
  assign mrdy  = {RREADY_M1, RREADY_M0};
  assign {RREADY_SDEFAULT, RREADY_S5, RREADY_S4, RREADY_S3, RREADY_S2, RREADY_S1, RREADY_S0} = rready;
  for (genvar m = 0; m < 2; m++) begin : g_lane
    state_t     st;
    logic [2:0] ptr, gnt, pick, idx, sel;
    logic       found;
    // Scan downward from ptr+6 so the last hit is the first candidate at or after ptr.
    always_comb begin
      pick = ptr;
      found = 1'b0;
      idx = '0;
      for (int i = NS - 1; i >= 0; i--) begin
        idx = 3'((int'(ptr) + i) % NS);
        if (vld[idx] && rid[idx][IDS_BITS-1:ID_BITS] == ID_BITS'(m + 1)) begin
          pick = idx;
          found = 1'b1;
        end
      end
    end
    assign sel = st == LOCK ? gnt : pick;
    assign sel_v[3*m +: 3] = sel;
    assign mv[m] = rst && (st == LOCK || found) && vld[sel];
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        st  <= IDLE;
        ptr <= '0;
        gnt <= '0;
      end else if (mv[m] && mrdy[m]) begin
        st  <= rlast[sel] ? IDLE : LOCK;
        gnt <= sel;
        if (rlast[sel]) ptr <= sel == 3'(NS - 1) ? '0 : sel + 3'd1;
      end
  end
  // Orphan tags are drained; matched slaves only see ready while they are the forwarded one.
  for (genvar k = 0; k < NS; k++) begin : g_rdy
    logic [ID_BITS-1:0] tag;
    assign tag = rid[k][IDS_BITS-1:ID_BITS];
    assign rready[k] = rst && vld[k] &&
                       ((tag != ID_BITS'(1) && tag != ID_BITS'(2)) ||
                        (mv[0] && mrdy[0] && sel_v[2:0] == 3'(k)) ||
                        (mv[1] && mrdy[1] && sel_v[5:3] == 3'(k)));
  end
  assign RVALID_M0 = mv[0];
  assign RID_M0    = mv[0] ? rid[sel_v[2:0]][ID_BITS-1:0] : '0;
  assign RDATA_M0  = mv[0] ? rdata[sel_v[2:0]] : '0;
  assign RRESP_M0  = mv[0] ? rresp[sel_v[2:0]] : '0;
  assign RLAST_M0  = mv[0] && rlast[sel_v[2:0]];
  assign RVALID_M1 = mv[1];
  assign RID_M1    = mv[1] ? rid[sel_v[5:3]][ID_BITS-1:0] : '0;
  assign RDATA_M1  = mv[1] ? rdata[sel_v[5:3]] : '0;
  assign RRESP_M1  = mv[1] ? rresp[sel_v[5:3]] : '0;
  assign RLAST_M1  = mv[1] && rlast[sel_v[5:3]];
endmodule

// File: tb/tb_r_channel_mux.sv
// tb_r_channel_mux: scenario tasks drive per-slave beat queues; a monitor scores master beats against expected queues
module tb_r_channel_mux;
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;
  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  rid   [7];
  logic [31:0] rdata [7];
  logic [1:0]  rresp [7];
  logic        rlast [7], svld [7];
  wire  [6:0]  srdy;
  logic [1:0]  mrdy = '0;
  wire  [3:0]  mid   [2];
  wire  [31:0] mdata [2];
  wire  [1:0]  mresp [2];
  wire  [1:0]  mlast, mvl;
  beat_t sq [7][$];
  beat_t mq [2][$];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  r_channel_mux dut (
    .clk(clk), .rst(rst),
    .RID_S0(rid[0]), .RID_S1(rid[1]), .RID_S2(rid[2]), .RID_S3(rid[3]), .RID_S4(rid[4]), .RID_S5(rid[5]), .RID_SDEFAULT(rid[6]),
    .RDATA_S0(rdata[0]), .RDATA_S1(rdata[1]), .RDATA_S2(rdata[2]), .RDATA_S3(rdata[3]), .RDATA_S4(rdata[4]), .RDATA_S5(rdata[5]), .RDATA_SDEFAULT(rdata[6]),
    .RRESP_S0(rresp[0]), .RRESP_S1(rresp[1]), .RRESP_S2(rresp[2]), .RRESP_S3(rresp[3]), .RRESP_S4(rresp[4]), .RRESP_S5(rresp[5]), .RRESP_SDEFAULT(rresp[6]),
    .RLAST_S0(rlast[0]), .RLAST_S1(rlast[1]), .RLAST_S2(rlast[2]), .RLAST_S3(rlast[3]), .RLAST_S4(rlast[4]), .RLAST_S5(rlast[5]), .RLAST_SDEFAULT(rlast[6]),
    .RVALID_S0(svld[0]), .RVALID_S1(svld[1]), .RVALID_S2(svld[2]), .RVALID_S3(svld[3]), .RVALID_S4(svld[4]), .RVALID_S5(svld[5]), .RVALID_SDEFAULT(svld[6]),
    .RREADY_S0(srdy[0]), .RREADY_S1(srdy[1]), .RREADY_S2(srdy[2]), .RREADY_S3(srdy[3]), .RREADY_S4(srdy[4]), .RREADY_S5(srdy[5]), .RREADY_SDEFAULT(srdy[6]),
    .RID_M0(mid[0]), .RID_M1(mid[1]), .RDATA_M0(mdata[0]), .RDATA_M1(mdata[1]),
    .RRESP_M0(mresp[0]), .RRESP_M1(mresp[1]), .RLAST_M0(mlast[0]), .RLAST_M1(mlast[1]),
    .RVALID_M0(mvl[0]), .RVALID_M1(mvl[1]), .RREADY_M0(mrdy[0]), .RREADY_M1(mrdy[1])
  );
  function automatic beat_t mk(input logic [3:0] tag, input logic [3:0] id, input logic [31:0] data, input logic last);
    return {tag, id, data, data[1:0], last};
  endfunction
  task automatic send(input int s, input int m, input beat_t b);
    sq[s].push_back(b);
    if (m >= 0) mq[m].push_back(b);
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  function automatic int pend();
    int p = 0;
    for (int k = 0; k < 7; k++) p += sq[k].size();
    for (int m = 0; m < 2; m++) p += mq[m].size();
    return p;
  endfunction
  task automatic drain();
    int n = 0;
    while (pend() != 0 && n < 100) begin
      cyc();
      n++;
    end
    checks++;
    if (pend() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d exp=0", pend());
      for (int k = 0; k < 7; k++) sq[k].delete();
      for (int m = 0; m < 2; m++) mq[m].delete();
    end
  endtask
  // Each slave presents the head of its queue and retires it after a sampled handshake.
  for (genvar k = 0; k < 7; k++) begin : g_src
    initial begin : drv
      bit    h;
      beat_t b;
      svld[k] = 1'b0; rid[k] = '0; rdata[k] = '0; rresp[k] = '0; rlast[k] = 1'b0;
      forever begin
        @(negedge clk);
        h = svld[k] && srdy[k];
        @(posedge clk);
        #1;
        if (h && sq[k].size() != 0) void'(sq[k].pop_front());
        b = sq[k].size() != 0 ? sq[k][0] : '0;
        svld[k] = sq[k].size() != 0;
        rid[k] = b.id; rdata[k] = b.data; rresp[k] = b.resp; rlast[k] = b.last;
      end
    end
  end
  always @(negedge clk) begin : mon
    beat_t e;
    for (int m = 0; m < 2; m++)
      if (rst && mvl[m] && mrdy[m]) begin
        checks++;
        if (mq[m].size() == 0) begin
          errors++;
          $display("FAIL m%0d_beat unexpected got id=%h data=%h", m, mid[m], mdata[m]);
        end else begin
          e = mq[m].pop_front();
          if ({mid[m], mdata[m], mresp[m], mlast[m]} !== {e.id[3:0], e.data, e.resp, e.last}) begin
            errors++;
            $display("FAIL m%0d_beat got id=%h data=%h resp=%0d last=%b exp id=%h data=%h resp=%0d last=%b",
                     m, mid[m], mdata[m], mresp[m], mlast[m], e.id[3:0], e.data, e.resp, e.last);
          end
        end
      end
  end
  task automatic test_reset();
    send(1, -1, mk(4'h1, 4'h3, 32'h1111_0000, 1'b0));
    send(6, -1, mk(4'h4, 4'h0, 32'h0000_0006, 1'b1));
    mrdy = 2'b11;
    repeat (2) cyc();
    @(negedge clk);
    checks++; if (mvl !== 2'b00) begin errors++; $display("FAIL rst_mvalid got=%b exp=00", mvl); end
    checks++; if (srdy !== 7'b0) begin errors++; $display("FAIL rst_sready got=%b exp=0000000", srdy); end
    checks++; if (mdata[0] !== 32'h0 || mid[0] !== 4'h0) begin errors++; $display("FAIL rst_mdata got=%h/%h exp=0/0", mdata[0], mid[0]); end
    checks++; if (dut.g_lane[0].ptr !== 3'd0 || dut.g_lane[1].ptr !== 3'd0) begin errors++; $display("FAIL rst_ptr got=%0d/%0d exp=0/0", dut.g_lane[0].ptr, dut.g_lane[1].ptr); end
    sq[1].delete();
    sq[6].delete();
    mrdy = '0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
  endtask
  task automatic test_single();
    mrdy = 2'b01;
    send(1, 0, mk(4'h1, 4'h3, 32'hDEAD_BEEF, 1'b1));
    cyc();
    @(negedge clk);
    checks++; if (mvl !== 2'b01) begin errors++; $display("FAIL single_mvalid got=%b exp=01", mvl); end
    checks++; if (mid[0] !== 4'h3) begin errors++; $display("FAIL single_rid got=%h exp=3", mid[0]); end
    checks++; if (srdy[1] !== 1'b1) begin errors++; $display("FAIL single_s1_rdy got=%b exp=1", srdy[1]); end
    cyc();
    @(negedge clk);
    checks++; if (dut.g_lane[0].ptr !== 3'd2) begin errors++; $display("FAIL single_ptr got=%0d exp=2", dut.g_lane[0].ptr); end
    checks++; if (1'(dut.g_lane[0].st) !== 1'b0) begin errors++; $display("FAIL single_state got=%b exp=0", 1'(dut.g_lane[0].st)); end
    drain();
  endtask
  task automatic test_burst_lock();
    mrdy = 2'b01;
    for (int i = 0; i < 4; i++) send(2, 0, mk(4'h1, 4'h5, 32'h2000 + i, i == 3));
    cyc();
    send(0, 0, mk(4'h1, 4'hA, 32'h0000_0A0A, 1'b1));
    @(negedge clk);
    checks++; if (srdy[2] !== 1'b1) begin errors++; $display("FAIL lock_s2_rdy got=%b exp=1", srdy[2]); end
    for (int i = 1; i < 4; i++) begin
      cyc();
      @(negedge clk);
      checks++; if (srdy[0] !== 1'b0) begin errors++; $display("FAIL lock_s0_rdy beat%0d got=%b exp=0", i, srdy[0]); end
      checks++; if (mdata[0] !== 32'h2000 + i) begin errors++; $display("FAIL lock_data beat%0d got=%h exp=%h", i, mdata[0], 32'h2000 + i); end
    end
    cyc();
    @(negedge clk);
    checks++; if (srdy[0] !== 1'b1 || mid[0] !== 4'hA) begin errors++; $display("FAIL lock_s0_grant got rdy=%b id=%h exp rdy=1 id=a", srdy[0], mid[0]); end
    checks++; if (dut.g_lane[0].ptr !== 3'd3) begin errors++; $display("FAIL lock_ptr got=%0d exp=3", dut.g_lane[0].ptr); end
    drain();
  endtask
  task automatic test_concurrent();
    mrdy = 2'b11;
    for (int i = 0; i < 4; i++) begin
      send(5, 0, mk(4'h1, 4'h5, 32'h5000 + i, i == 3));
      send(3, 1, mk(4'h2, 4'h3, 32'h3000 + i, i == 3));
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      checks++; if (mvl !== 2'b11) begin errors++; $display("FAIL conc_mvalid cyc%0d got=%b exp=11", i, mvl); end
      checks++; if ({srdy[5], srdy[3]} !== 2'b11) begin errors++; $display("FAIL conc_sready cyc%0d got=%b exp=11", i, {srdy[5], srdy[3]}); end
      checks++; if (mid[0] !== 4'h5 || mid[1] !== 4'h3) begin errors++; $display("FAIL conc_route cyc%0d got=%h/%h exp=5/3", i, mid[0], mid[1]); end
    end
    drain();
  endtask
  task automatic test_orphan_backpressure();
    mrdy = 2'b11;
    send(6, -1, mk(4'h4, 4'h6, 32'h0000_6666, 1'b1));
    cyc();
    @(negedge clk);
    checks++; if (srdy[6] !== 1'b1) begin errors++; $display("FAIL orphan_rdy got=%b exp=1", srdy[6]); end
    checks++; if (mvl !== 2'b00) begin errors++; $display("FAIL orphan_mvalid got=%b exp=00", mvl); end
    for (int i = 0; i < 4; i++) send(1, 0, mk(4'h1, 4'h1, 32'h1000 + i, i == 3));
    cyc();
    @(negedge clk);
    cyc();
    mrdy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (mvl[0] !== 1'b1 || mdata[0] !== 32'h1001) begin errors++; $display("FAIL bp_hold cyc%0d got v=%b data=%h exp v=1 data=00001001", i, mvl[0], mdata[0]); end
      checks++; if (srdy[1] !== 1'b0) begin errors++; $display("FAIL bp_stall cyc%0d got=%b exp=0", i, srdy[1]); end
      cyc();
    end
    mrdy[0] = 1'b1;
    drain();
  endtask
  task automatic test_round_robin();
    logic [3:0] e;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    mrdy = 2'b10;
    for (int i = 0; i < 3; i++) begin
      send(0, 1, mk(4'h2, 4'h1, 32'h100 + i, 1'b1));
      send(4, 1, mk(4'h2, 4'h4, 32'h400 + i, 1'b1));
    end
    for (int i = 0; i < 6; i++) begin
      e = i % 2 == 1 ? 4'h4 : 4'h1;
      cyc();
      @(negedge clk);
      checks++; if (mid[1] !== e) begin errors++; $display("FAIL rr_grant cyc%0d got=%h exp=%h", i, mid[1], e); end
    end
    drain();
  endtask
  task automatic test_reset_mid_burst();
    beat_t b3;
    mrdy = 2'b01;
    send(1, 0, mk(4'h1, 4'h7, 32'h7000, 1'b0));
    for (int i = 1; i < 4; i++) sq[1].push_back(mk(4'h1, 4'h7, 32'h7000 + i, i == 3));
    cyc();
    @(negedge clk);
    cyc();
    checks++; if (1'(dut.g_lane[0].st) !== 1'b1) begin errors++; $display("FAIL rmb_locked got=%b exp=1", 1'(dut.g_lane[0].st)); end
    rst = 1'b0;
    #1;
    checks++; if (mvl !== 2'b00 || srdy !== 7'b0) begin errors++; $display("FAIL rmb_outputs got v=%b rdy=%b exp v=00 rdy=0000000", mvl, srdy); end
    checks++; if (mdata[0] !== 32'h0 || mid[0] !== 4'h0) begin errors++; $display("FAIL rmb_mdata got=%h/%h exp=0/0", mdata[0], mid[0]); end
    checks++; if (1'(dut.g_lane[0].st) !== 1'b0 || dut.g_lane[0].ptr !== 3'd0) begin errors++; $display("FAIL rmb_state got st=%b ptr=%0d exp st=0 ptr=0", 1'(dut.g_lane[0].st), dut.g_lane[0].ptr); end
    sq[1].delete();
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    checks++; if (1'(dut.g_lane[0].st) !== 1'b0 || dut.g_lane[0].ptr !== 3'd0) begin errors++; $display("FAIL rmb_release got st=%b ptr=%0d exp st=0 ptr=0", 1'(dut.g_lane[0].st), dut.g_lane[0].ptr); end
    b3 = mk(4'h1, 4'h3, 32'h0000_3333, 1'b1);
    sq[3].push_back(b3);
    send(0, 0, mk(4'h1, 4'h0, 32'h0000_0000, 1'b1));
    mq[0].push_back(b3);
    cyc();
    drain();
  endtask
  initial begin
    test_reset();
    test_single();
    test_burst_lock();
    test_concurrent();
    test_orphan_backpressure();
    test_round_robin();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
